// File: rtl/ecc_pkg.sv
// ecc_pkg: shared constants, state encoding and helpers for the
// ECC word-serial front end.
package ecc_pkg;

   localparam int DATA_WIDTH = 256;
   localparam int WORD_WIDTH = 32;
   localparam int WORDS      = DATA_WIDTH / WORD_WIDTH;
   localparam int LOAD_CNT_W = $clog2(3 * WORDS);
   localparam int OUT_CNT_W  = $clog2(2 * WORDS);

   typedef enum logic [1:0] {
      LOAD,
      FIRE,
      WAIT,
      SEND
   } io_state_e;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ecc_serial_io_piso.sv
// ecc_piso: parallel-load shift register emitting its low word,
// shifting right one word per shift enable.
module ecc_piso
#(
   parameter int TOTAL_W = 512,
   parameter int STEP_W  = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic               shift_i,
   input  logic [TOTAL_W-1:0] data_i,
   output logic [STEP_W-1:0]  word_o
);

   import ecc_pkg::*;

   logic [TOTAL_W-1:0] sr_q;
   logic [TOTAL_W-1:0] sr_d;

   // load wins over shift; vacated words fill with zero
   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         sr_d = sr_q >> STEP_W;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign word_o = sr_q[STEP_W-1:0];

endmodule

// File: rtl/ecc_serial_io.sv
// ecc_serial_io: word-serial loader/unloader for the ECC scalar core.
// Optional ECC_IO_ZERO_BYPASS_EN skips the core when k == 0.
module ecc_serial_io
#(
   parameter int DATA_WIDTH = 256,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WORD_WIDTH-1:0] s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WORD_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] core_Px,
   output logic [DATA_WIDTH-1:0] core_Py,
   output logic [DATA_WIDTH-1:0] core_k,
   output logic                  core_in_valid,
   input  logic [DATA_WIDTH-1:0] core_Rx,
   input  logic [DATA_WIDTH-1:0] core_Ry,
   input  logic                  core_out_valid
);

   import ecc_pkg::*;

   localparam int NW  = DATA_WIDTH / WORD_WIDTH;
   localparam int LCW = cnt_w(3 * NW);
   localparam int OCW = cnt_w(2 * NW);
   localparam int PW  = cnt_w(NW);

   localparam logic [LCW-1:0] LOAD_LAST  = LCW'(3 * NW - 1);
   localparam logic [OCW-1:0] OUT_PENULT = OCW'(2 * NW - 2);

   io_state_e             state_q;
   logic [LCW-1:0]        lcnt_q;
   logic [OCW-1:0]        ocnt_q;
   logic [DATA_WIDTH-1:0] px_q;
   logic [DATA_WIDTH-1:0] py_q;
   logic [DATA_WIDTH-1:0] k_q;
   logic                  s_ready_q;
   logic                  busy_q;
   logic                  fire_q;
   logic                  m_valid_q;
   logic                  m_last_q;

   logic [1:0]            op_sel;
   logic [PW-1:0]         word_sel;
   logic                  in_hs;
   logic                  load_last;
   logic                  out_hs;
   logic                  capture;
   logic                  zero_fire;
   logic                  pis_load;
   logic [2*DATA_WIDTH-1:0] pis_data;

   always_comb begin
      op_sel   = 2'(int'(lcnt_q) / NW);
      word_sel = PW'(int'(lcnt_q) % NW);
   end

   assign in_hs     = s_valid && s_ready_q;
   assign load_last = in_hs && (lcnt_q == LOAD_LAST);
   assign out_hs    = m_valid_q && m_ready;
   assign capture   = (state_q == WAIT) && core_out_valid;

`ifdef ECC_IO_ZERO_BYPASS_EN
   logic [DATA_WIDTH-1:0] k_nxt;

   // the final input word is always the top word of k
   always_comb begin
      k_nxt = k_q;
      k_nxt[(NW-1)*WORD_WIDTH +: WORD_WIDTH] = s_data;
   end

   assign zero_fire = (k_nxt == '0);
`else
   assign zero_fire = 1'b0;
`endif

   assign pis_load = capture || ((state_q == FIRE) && !fire_q);
   assign pis_data = capture ? {core_Ry, core_Rx} : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD;
         lcnt_q    <= '0;
         ocnt_q    <= '0;
         px_q      <= '0;
         py_q      <= '0;
         k_q       <= '0;
         s_ready_q <= 1'b1;
         busy_q    <= 1'b0;
         fire_q    <= 1'b0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
      end else begin
         unique case (state_q)
            LOAD: begin
               if (in_hs) begin
                  unique case (op_sel)
                     2'd0: px_q[word_sel*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                     2'd1: py_q[word_sel*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                     default: k_q[word_sel*WORD_WIDTH +: WORD_WIDTH] <= s_data;
                  endcase
                  if (load_last) begin
                     lcnt_q    <= '0;
                     state_q   <= FIRE;
                     s_ready_q <= 1'b0;
                     busy_q    <= 1'b1;
                     fire_q    <= !zero_fire;
                  end else begin
                     lcnt_q <= lcnt_q + 1'b1;
                  end
               end
            end
            FIRE: begin
               fire_q <= 1'b0;
               if (fire_q) begin
                  state_q <= WAIT;
               end else begin
                  state_q   <= SEND;
                  m_valid_q <= 1'b1;
               end
            end
            WAIT: begin
               if (core_out_valid) begin
                  state_q   <= SEND;
                  m_valid_q <= 1'b1;
               end
            end
            SEND: begin
               if (out_hs) begin
                  if (m_last_q) begin
                     state_q   <= LOAD;
                     ocnt_q    <= '0;
                     m_valid_q <= 1'b0;
                     m_last_q  <= 1'b0;
                     busy_q    <= 1'b0;
                     s_ready_q <= 1'b1;
                  end else begin
                     ocnt_q   <= ocnt_q + 1'b1;
                     m_last_q <= (ocnt_q == OUT_PENULT);
                  end
               end
            end
            default: state_q <= LOAD;
         endcase
      end
   end

   ecc_piso #(
      .TOTAL_W (2 * DATA_WIDTH),
      .STEP_W  (WORD_WIDTH)
   ) u_piso (
      .clk     (clk),
      .rst     (rst),
      .load_i  (pis_load),
      .shift_i (out_hs),
      .data_i  (pis_data),
      .word_o  (m_data)
   );

   assign s_ready       = s_ready_q;
   assign busy          = busy_q;
   assign core_in_valid = fire_q;
   assign m_valid       = m_valid_q;
   assign m_last        = m_last_q;
   assign core_Px       = px_q;
   assign core_Py       = py_q;
   assign core_k        = k_q;

endmodule

// File: tb/tb_ecc_serial_io.sv
// tb_ecc_serial_io: directed vector table plus reset and stall
// sequences for ecc_serial_io, with a simple core stub.
module tb_ecc_serial_io;

   localparam int DW = 256;
   localparam int WW = 32;
   localparam int NW = DW / WW;

`ifdef ECC_IO_ZERO_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid;
   logic          s_ready;
   logic [WW-1:0] s_data;
   logic          m_valid;
   logic          m_ready;
   logic [WW-1:0] m_data;
   logic          m_last;
   logic          busy;
   logic [DW-1:0] core_Px;
   logic [DW-1:0] core_Py;
   logic [DW-1:0] core_k;
   logic          core_in_valid;
   logic [DW-1:0] core_Rx;
   logic [DW-1:0] core_Ry;
   logic          core_out_valid;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DW-1:0] px;
      logic [DW-1:0] py;
      logic [DW-1:0] k;
      logic [DW-1:0] rx;
      logic [DW-1:0] ry;
      bit            toggle;
      bit            rnd;
      int            spur;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   ecc_serial_io dut (
      .clk            (clk),
      .rst            (rst),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_last         (m_last),
      .busy           (busy),
      .core_Px        (core_Px),
      .core_Py        (core_Py),
      .core_k         (core_k),
      .core_in_valid  (core_in_valid),
      .core_Rx        (core_Rx),
      .core_Ry        (core_Ry),
      .core_out_valid (core_out_valid)
   );

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ends on the negedge of the cycle after the last input handshake
   task automatic load_ops(input vec_t v, output bit fired);
      int hs = 0;
      int i = 0;
      int cyc = 0;
      int early = 0;
      int mv_bad = 0;
      bit acc;
      logic [DW-1:0] op;
      fired = !(BYPASS_EN && (v.k == '0));
      while (i < 3 * NW && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (core_in_valid) early++;
         if (m_valid) mv_bad++;
         core_out_valid = (i == v.spur);
         core_Rx = {8{32'hC0FFEE00}};
         core_Ry = {8{32'h0BADF00D}};
         if (v.toggle && (cyc % 2 == 0)) begin
            s_valid = 1'b0;
            s_data  = 32'hBAD0BAD0;
         end else begin
            op = (i < NW) ? v.px : (i < 2 * NW) ? v.py : v.k;
            s_valid = 1'b1;
            s_data  = op[(i % NW)*WW +: WW];
         end
         acc = s_valid && s_ready;
         @(posedge clk);
         if (acc) begin
            hs++;
            i++;
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
      core_out_valid = 1'b0;
      chk("handshakes", hs, 3 * NW);
      chk("no_early_fire", early, 0);
      chk("no_mvalid_in_load", mv_bad, 0);
      chk("fire_pulse", core_in_valid, fired);
      chk("busy_after_load", busy, 1);
      chk("s_ready_after_load", s_ready, 0);
      chk("mvalid_n1", m_valid, 0);
      chk("core_Px", core_Px, v.px);
      chk("core_Py", core_Py, v.py);
      chk("core_k", core_k, v.k);
   endtask

   // core stub: answers 20 cycles after start; k == 0 yields (0,0)
   task automatic respond(input bit fired);
      int extra = 0;
      if (fired) begin
         @(negedge clk);
         chk("fire_single", core_in_valid, 0);
         repeat (19) begin
            @(negedge clk);
            if (core_in_valid) extra++;
         end
         chk("no_refire", extra, 0);
         core_Rx = (core_k == '0) ? '0 : core_Px ^ core_k;
         core_Ry = (core_k == '0) ? '0 : core_Py + 1'b1;
         core_out_valid = 1'b1;
         @(negedge clk);
         core_out_valid = 1'b0;
         core_Rx = '1;
         core_Ry = '1;
         chk("mvalid_after_result", m_valid, 1);
      end else begin
         @(negedge clk);
         chk("bypass_mvalid_n2", m_valid, 1);
      end
   endtask

   task automatic drain(input vec_t v);
      int got = 0;
      int cyc = 0;
      int unstable = 0;
      bit stall = 1'b0;
      logic [WW-1:0] prev = '0;
      logic [2*DW-1:0] exp_all;
      exp_all = {v.ry, v.rx};
      while (got < 2 * NW && cyc < 400) begin
         if (cyc > 0) @(negedge clk);
         cyc++;
         if (stall && (m_data !== prev)) unstable++;
         m_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_valid && m_ready) begin
            chk($sformatf("word%0d", got), m_data, exp_all[got*WW +: WW]);
            chk($sformatf("last%0d", got), m_last, (got == 2 * NW - 1));
            got++;
         end
         stall = m_valid && !m_ready;
         prev  = m_data;
      end
      @(negedge clk);
      m_ready = 1'b0;
      chk("word_count", got, 2 * NW);
      chk("stall_stable", unstable, 0);
      chk("busy_after_send", busy, 0);
      chk("s_ready_after_send", s_ready, 1);
      chk("mvalid_after_send", m_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      bit fired;
      vecs[0] = '{{32{8'h01}}, {32{8'h02}}, 256'h3,
                  {{31{8'h01}}, 8'h02}, {{31{8'h02}}, 8'h03},
                  1'b0, 1'b0, -1};
      vecs[1] = '{{32{8'h01}}, {32{8'h02}}, 256'h3,
                  {{31{8'h01}}, 8'h02}, {{31{8'h02}}, 8'h03},
                  1'b1, 1'b0, 5};
      vecs[2] = '{{8{32'h12345678}}, {8{32'h89ABCDEF}},
                  {8{32'h0000FFFF}}, {8{32'h1234A987}},
                  {{7{32'h89ABCDEF}}, 32'h89ABCDF0},
                  1'b0, 1'b1, -1};
      vecs[3] = '{{8{32'h12345678}}, {8{32'h89ABCDEF}}, '0, '0, '0,
                  1'b0, 1'b0, 2};
      vecs[4] = '{{8{32'hFFFFFFFF}}, {8{32'hFFFFFFFF}},
                  {32'h80000000, 224'h0},
                  {32'h7FFFFFFF, {7{32'hFFFFFFFF}}}, '0,
                  1'b1, 1'b1, -1};

      rst = 1'b1;
      s_valid = 1'b0;
      s_data = '0;
      m_ready = 1'b0;
      core_Rx = '0;
      core_Ry = '0;
      core_out_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_core_in_valid", core_in_valid, 0);
      chk("rst_ops", {core_Px ^ core_Py ^ core_k}, 0);
      rst = 1'b0;

      // spurious result strobe while idle
      @(negedge clk);
      core_out_valid = 1'b1;
      @(negedge clk);
      core_out_valid = 1'b0;
      chk("spur_idle_mvalid", m_valid, 0);
      chk("spur_idle_busy", busy, 0);

      // reset during a partial load discards it
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         s_valid = 1'b1;
         s_data = 32'h5A5A0000 + 32'(i);
      end
      @(negedge clk);
      s_valid = 1'b0;
      chk("partial_px", core_Px[WW-1:0], 32'h5A5A0000);
      rst = 1'b1;
      @(negedge clk);
      chk("partial_rst_px", core_Px, 0);
      chk("partial_rst_py", core_Py, 0);
      rst = 1'b0;

      // reset while SEND is stalled
      load_ops(vecs[0], fired);
      respond(fired);
      repeat (3) @(negedge clk);
      chk("stall_mvalid", m_valid, 1);
      chk("stall_word0", m_data, vecs[0].rx[WW-1:0]);
      rst = 1'b1;
      @(negedge clk);
      chk("send_rst_mvalid", m_valid, 0);
      chk("send_rst_s_ready", s_ready, 1);
      chk("send_rst_busy", busy, 0);
      chk("send_rst_m_data", m_data, 0);
      chk("send_rst_px", core_Px, 0);
      rst = 1'b0;

      for (int n = 0; n < 5; n++) begin
         load_ops(vecs[n], fired);
         respond(fired);
         drain(vecs[n]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
